// File: rtl/da_vinci_run_ctrl.sv
// da_vinci_run_ctrl: reset sequencing, run watchdog, halt detect and memory-window dump for the DA_VINCI core
module da_vinci_run_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 26,
  parameter int RST_HOLD_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 500,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR = 26'h3ffffff,
  parameter logic [ADDR_WIDTH-1:0] DUMP_BASE = 26'h3fffff0,
  parameter int DUMP_DEPTH = 16,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] BUS_ADDR,
  input  logic                  BUS_WRITE,
  output logic                  CPU_RST_N,
  output logic                  CPU_HOLD,
  output logic [ADDR_WIDTH-1:0] DUMP_ADDR,
  output logic                  DUMP_READ,
  input  logic [DATA_WIDTH-1:0] DUMP_RDATA,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [ADDR_WIDTH-1:0] OUT_INDEX,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [31:0]           CYCLE_COUNT,
  output logic                  DONE,
  output logic [1:0]            DONE_CAUSE
);
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_REQ, S_WAIT, S_OUT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d, cycle_q, cycle_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, out_index_q, out_index_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  logic [1:0] cause_q, cause_d;
  logic halt, tmo;
  assign halt = BUS_WRITE && BUS_ADDR == HALT_ADDR;
  assign tmo = TIMEOUT_CYCLES != 0 && cycle_q == 32'(TIMEOUT_CYCLES - 1);
  assign CPU_RST_N = !(state_q == S_IDLE || state_q == S_HOLD);
  assign CPU_HOLD = state_q != S_RUN;
  assign DUMP_READ = state_q == S_REQ;
  assign DUMP_ADDR = DUMP_READ ? DUMP_BASE + idx_q : '0;
  assign DONE = state_q == S_DONE;
  assign OUT_DATA = out_data_q;
  assign OUT_INDEX = out_index_q;
  assign OUT_VALID = out_valid_q;
  assign CYCLE_COUNT = cycle_q;
  assign DONE_CAUSE = cause_q;
  // next state: one outstanding read at a time, word held until the sink takes it
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cycle_d = cycle_q;
    idx_d = idx_q;
    cause_d = cause_q;
    out_data_d = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE, S_DONE: if (START) begin
        cycle_d = '0;
        cause_d = 2'b00;
        idx_d = '0;
        cnt_d = '0;
        state_d = RST_HOLD_CYCLES == 0 ? S_RUN : S_HOLD;
      end
      S_HOLD: if (cnt_q == 32'(RST_HOLD_CYCLES - 1)) state_d = S_RUN;
        else cnt_d = cnt_q + 32'd1;
      S_RUN: begin
        cycle_d = &cycle_q ? cycle_q : cycle_q + 32'd1;
        if (halt || tmo) begin
          cause_d = halt ? 2'b01 : 2'b10;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (cnt_q == 32'(MEM_RD_LATENCY - 1)) begin
        out_data_d = DUMP_RDATA;
        out_index_d = idx_q;
        out_valid_d = 1'b1;
        state_d = S_OUT;
      end else cnt_d = cnt_q + 32'd1;
      S_OUT: if (OUT_READY) begin
        out_valid_d = 1'b0;
        if (idx_q == ADDR_WIDTH'(DUMP_DEPTH - 1)) state_d = S_DONE;
        else begin
          idx_d = idx_q + 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state registers with synchronous reset that drops any in-flight read
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      cycle_q <= '0;
      idx_q <= '0;
      cause_q <= 2'b00;
      out_data_q <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cycle_q <= cycle_d;
      idx_q <= idx_d;
      cause_q <= cause_d;
      out_data_q <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_da_vinci_run_ctrl.sv
// tb_da_vinci_run_ctrl: directed run/halt/timeout/stall/reset scenarios with a dump scoreboard
module tb_da_vinci_run_ctrl;
  localparam int DW = 32;
  localparam int AW = 26;
  localparam logic [AW-1:0] BASE0 = 26'h3fffff0;
  localparam logic [AW-1:0] BASE1 = 26'h1000000;
  typedef struct {logic [AW-1:0] idx; logic [DW-1:0] data;} exp_t;
  logic CLK = 0, RST = 1, START0 = 0, START1 = 0, BUS_WRITE = 0;
  logic [AW-1:0] BUS_ADDR = '0;
  logic rst_n0, hold0, dread0, ovalid0, done0, ready0 = 1;
  logic rst_n1, hold1, dread1, ovalid1, done1, ready1 = 1;
  logic [AW-1:0] daddr0, oidx0, daddr1, oidx1;
  logic [DW-1:0] rdata0, odata0, rdata1, odata1;
  logic [31:0] ccount0, ccount1;
  logic [1:0] cause0, cause1;
  int checks = 0, errors = 0, xfers0 = 0, stall_n = 0;
  bit rnd = 0, stalled = 0;
  logic [DW-1:0] sd;
  logic [AW-1:0] si;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  logic pv0 = 0;
  logic [AW-1:0] pa0;
  logic [2:0] pv1 = '0;
  logic [AW-1:0] pa1 [3];

  da_vinci_run_ctrl u0 (
    .CLK(CLK), .RST(RST), .START(START0), .BUS_ADDR(BUS_ADDR), .BUS_WRITE(BUS_WRITE),
    .CPU_RST_N(rst_n0), .CPU_HOLD(hold0), .DUMP_ADDR(daddr0), .DUMP_READ(dread0),
    .DUMP_RDATA(rdata0), .OUT_DATA(odata0), .OUT_INDEX(oidx0), .OUT_VALID(ovalid0),
    .OUT_READY(ready0), .CYCLE_COUNT(ccount0), .DONE(done0), .DONE_CAUSE(cause0));

  da_vinci_run_ctrl #(.TIMEOUT_CYCLES(20), .DUMP_BASE(BASE1), .DUMP_DEPTH(4), .MEM_RD_LATENCY(3)) u1 (
    .CLK(CLK), .RST(RST), .START(START1), .BUS_ADDR(BUS_ADDR), .BUS_WRITE(BUS_WRITE),
    .CPU_RST_N(rst_n1), .CPU_HOLD(hold1), .DUMP_ADDR(daddr1), .DUMP_READ(dread1),
    .DUMP_RDATA(rdata1), .OUT_DATA(odata1), .OUT_INDEX(oidx1), .OUT_VALID(ovalid1),
    .OUT_READY(ready1), .CYCLE_COUNT(ccount1), .DONE(done1), .DONE_CAUSE(cause1));

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return {6'h15, a} ^ 32'h9e3779b9;
  endfunction

  // memory models: data is only valid exactly the read latency after the strobe
  always @(posedge CLK) begin
    pv0 <= dread0;
    pa0 <= daddr0;
    pv1 <= {pv1[1:0], dread1};
    pa1[0] <= daddr1;
    pa1[1] <= pa1[0];
    pa1[2] <= pa1[1];
  end
  assign rdata0 = pv0 ? mem(pa0) : 32'hdeadbeef;
  assign rdata1 = pv1[2] ? mem(pa1[2]) : 32'hdeadbeef;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // u0 sink: drives OUT_READY, checks stall stability and scoreboards each transfer
  initial forever begin
    @(negedge CLK);
    if (stalled) begin
      chk("stall_valid", ovalid0, 1);
      chk("stall_data", odata0, sd);
      chk("stall_idx", oidx0, si);
    end
    if (!rnd) ready0 = 1;
    else if (ovalid0 && oidx0 == 3 && stall_n < 10) begin
      ready0 = 0;
      stall_n++;
    end else ready0 = 1'($urandom_range(0, 1));
    if (ovalid0 && ready0) begin
      xfers0++;
      chk("sb_nonempty", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("out_idx", oidx0, e0.idx);
        chk("out_data", odata0, e0.data);
      end
    end
    stalled = ovalid0 && !ready0;
    sd = odata0;
    si = oidx0;
  end

  task automatic start_run0();
    START0 = 1;
    for (int i = 0; i < 16; i++) q0.push_back('{AW'(i), mem(BASE0 + AW'(i))});
    @(negedge CLK);
    START0 = 0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_n_low", rst_n0, 0);
      @(negedge CLK);
    end
    chk("rst_n_high", rst_n0, 1);
    chk("run_hold", hold0, 0);
    chk("run_count0", ccount0, 0);
  endtask

  task automatic halt_at0(input int n);
    repeat (n) @(negedge CLK);
    chk("pre_halt_count", ccount0, 64'(n));
    chk("pre_halt_hold", hold0, 0);
    BUS_ADDR = 26'h3ffffff;
    BUS_WRITE = 1;
    @(negedge CLK);
    BUS_WRITE = 0;
    BUS_ADDR = '0;
    chk("halt_hold", hold0, 1);
    chk("halt_rst_n", rst_n0, 1);
    chk("halt_count", ccount0, 64'(n + 1));
    chk("halt_cause", cause0, 1);
  endtask

  task automatic wait_done0();
    for (int i = 0; i < 3000 && !done0; i++) @(negedge CLK);
    chk("done0", done0, 1);
    chk("sb_drained", q0.size(), 0);
  endtask

  task automatic chk_reset0();
    chk("r_rst_n", rst_n0, 0);
    chk("r_hold", hold0, 1);
    chk("r_read", dread0, 0);
    chk("r_addr", daddr0, 0);
    chk("r_valid", ovalid0, 0);
    chk("r_data", odata0, 0);
    chk("r_idx", oidx0, 0);
    chk("r_count", ccount0, 0);
    chk("r_done", done0, 0);
    chk("r_cause", cause0, 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk_reset0();
    RST = 0;
    @(negedge CLK);
    chk("idle_rst_n", rst_n0, 0);
    start_run0();
    wait_done0();
    chk("to_count", ccount0, 500);
    chk("to_cause", cause0, 2);
    chk("to_xfers", xfers0, 16);
    chk("to_hold", hold0, 1);
    xfers0 = 0;
    rnd = 1;
    start_run0();
    halt_at0(37);
    wait_done0();
    rnd = 0;
    chk("h37_count", ccount0, 38);
    chk("h37_cause", cause0, 1);
    chk("h37_xfers", xfers0, 16);
    chk("h37_stalls", stall_n, 10);
    xfers0 = 0;
    start_run0();
    halt_at0(499);
    wait_done0();
    chk("h499_count", ccount0, 500);
    chk("h499_cause", cause0, 1);
    chk("h499_xfers", xfers0, 16);
    start_run0();
    halt_at0(5);
    for (int i = 0; i < 200 && !(dread0 && daddr0 == BASE0 + 26'd5); i++) @(negedge CLK);
    chk("read5_seen", dread0 && daddr0 == BASE0 + 26'd5, 1);
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    q0.delete();
    xfers0 = 0;
    chk_reset0();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("post_rst_valid", ovalid0, 0);
    end
    chk("post_rst_xfers", xfers0, 0);
    start_run0();
    halt_at0(10);
    wait_done0();
    chk("rerun_count", ccount0, 11);
    chk("rerun_xfers", xfers0, 16);
    START1 = 1;
    for (int i = 0; i < 4; i++) q1.push_back('{AW'(i), mem(BASE1 + AW'(i))});
    @(negedge CLK);
    START1 = 0;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 100 && !dread1; i++) @(negedge CLK);
      chk("l3_read_seen", dread1, 1);
      chk("l3_addr", daddr1, BASE1 + AW'(w));
      for (int k = 0; k < 3; k++) begin
        @(negedge CLK);
        chk("l3_early", ovalid1, 0);
      end
      @(negedge CLK);
      chk("l3_valid", ovalid1, 1);
      e1 = q1.pop_front();
      chk("l3_idx", oidx1, e1.idx);
      chk("l3_data", odata1, e1.data);
    end
    for (int i = 0; i < 20 && !done1; i++) @(negedge CLK);
    chk("l3_done", done1, 1);
    chk("l3_cause", cause1, 2);
    chk("l3_count", ccount1, 20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
